// File: rtl/half_pwm_seq.sv
// Burst sequencer for the half_pwm_die pulse generator: stages timing config,
// shadows it on each accepted start, fires io_en per period and counts completions.
module half_pwm_seq #(
    parameter int _RAM_WIDTH = 32,
    parameter int _CNT_WIDTH = 16
) (
    input  logic                  io_clk,
    input  logic                  io_rst,
    input  logic                  cfg_wr,
    input  logic [_RAM_WIDTH-1:0] cfg_die_period,
    input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
    input  logic [_CNT_WIDTH-1:0] cfg_burst_count,
    input  logic [_CNT_WIDTH-1:0] cfg_gap,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pulse_valid,
    output logic [_RAM_WIDTH-1:0] die_period,
    output logic [_RAM_WIDTH-1:0] pulse_period,
    output logic                  io_en,
    output logic                  pwm_dis,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  cfg_err,
    output logic [_CNT_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [_CNT_WIDTH-1:0] CNT_ONE = {{(_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [_RAM_WIDTH-1:0]   stg_die;
    logic [_RAM_WIDTH-1:0]   stg_pulse;
    logic [_CNT_WIDTH-1:0]   stg_burst;
    logic [_CNT_WIDTH-1:0]   stg_gap;
    logic [_CNT_WIDTH-1:0]   gap_lat;
    logic [_CNT_WIDTH-1:0]   gap_cnt;
    logic [_CNT_WIDTH-1:0]   remaining;
    logic [1:0]              abort_cnt;
    logic                    stg_bad;
    logic                    nxt_bad;
    logic                    abort_req;

    always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
            stg_die   <= '0;
            stg_pulse <= '0;
            stg_burst <= '0;
            stg_gap   <= '0;
        end else if (cfg_wr) begin
            stg_die   <= cfg_die_period;
            stg_pulse <= cfg_pulse_period;
            stg_burst <= cfg_burst_count;
            stg_gap   <= cfg_gap;
        end
    end

    // cfg_err must coincide with LOAD, so the check is made one edge early
    // against the staging contents LOAD will actually see.
    always_comb begin
        stg_bad = (stg_die == '0) || (stg_pulse == '0) || (stg_burst == '0);
        nxt_bad = stg_bad;
        if (cfg_wr) begin
            nxt_bad = (cfg_die_period == '0) || (cfg_pulse_period == '0) ||
                      (cfg_burst_count == '0);
        end
        abort_req = stop && ((state == S_LOAD) || (state == S_FIRE) ||
                             (state == S_WAIT) || (state == S_GAP));
    end

    always_ff @(posedge io_clk or negedge io_rst) begin
        if (!io_rst) begin
            state        <= S_IDLE;
            die_period   <= '0;
            pulse_period <= '0;
            io_en        <= 1'b0;
            pwm_dis      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            cfg_err      <= 1'b0;
            cycle_cnt    <= '0;
            gap_lat      <= '0;
            gap_cnt      <= '0;
            remaining    <= '0;
            abort_cnt    <= '0;
        end else begin
            io_en   <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            cfg_err <= 1'b0;
            if (abort_req) begin
                state     <= S_ABORT;
                pwm_dis   <= 1'b1;
                abort_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state   <= S_LOAD;
                            busy    <= 1'b1;
                            cfg_err <= nxt_bad;
                        end
                    end
                    S_LOAD: begin
                        if (stg_bad) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            die_period   <= stg_die;
                            pulse_period <= stg_pulse;
                            remaining    <= stg_burst;
                            gap_lat      <= stg_gap;
                            cycle_cnt    <= '0;
                            io_en        <= 1'b1;
                            state        <= S_FIRE;
                        end
                    end
                    S_FIRE: state <= S_WAIT;
                    S_WAIT: begin
                        if (pulse_valid) begin
                            cycle_cnt <= cycle_cnt + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (remaining == CNT_ONE) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (gap_lat == '0) begin
                                state <= S_FIRE;
                                io_en <= 1'b1;
                            end else begin
                                gap_cnt <= gap_lat;
                                state   <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == CNT_ONE) begin
                            state <= S_FIRE;
                            io_en <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    S_ABORT: begin
                        // two cycles of pwm_dis, then one cycle of aborted before IDLE
                        case (abort_cnt)
                            2'd0: abort_cnt <= 2'd1;
                            2'd1: begin
                                pwm_dis   <= 1'b0;
                                aborted   <= 1'b1;
                                abort_cnt <= 2'd2;
                            end
                            default: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_half_pwm_seq.sv
// Directed plus randomized bench for half_pwm_seq; expectations come from a
// per-burst event schedule (fire/completion windows) computed arithmetically.
module tb_half_pwm_seq;

    logic        io_clk = 1'b0;
    logic        io_rst = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [31:0] cfg_die_period = '0;
    logic [31:0] cfg_pulse_period = '0;
    logic [15:0] cfg_burst_count = '0;
    logic [15:0] cfg_gap = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pulse_valid = 1'b0;
    logic [31:0] die_period;
    logic [31:0] pulse_period;
    logic        io_en;
    logic        pwm_dis;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        cfg_err;
    logic [15:0] cycle_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sh_die = '0;
    logic [31:0] sh_pul = '0;
    logic [15:0] prev_cnt = '0;

    half_pwm_seq #(._RAM_WIDTH(32), ._CNT_WIDTH(16)) dut (
        .io_clk           (io_clk),
        .io_rst           (io_rst),
        .cfg_wr           (cfg_wr),
        .cfg_die_period   (cfg_die_period),
        .cfg_pulse_period (cfg_pulse_period),
        .cfg_burst_count  (cfg_burst_count),
        .cfg_gap          (cfg_gap),
        .start            (start),
        .stop             (stop),
        .pulse_valid      (pulse_valid),
        .die_period       (die_period),
        .pulse_period     (pulse_period),
        .io_en            (io_en),
        .pwm_dis          (pwm_dis),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
        .cfg_err          (cfg_err),
        .cycle_cnt        (cycle_cnt)
    );

    always #5 io_clk = ~io_clk;

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph, input int w, input bit e_busy, input bit e_en,
                             input bit e_done, input bit e_dis, input bit e_abt, input bit e_err,
                             input logic [15:0] e_cnt, input logic [31:0] e_die,
                             input logic [31:0] e_pul);
        string t;
        t = $sformatf("%s w%0d", ph, w);
        chk({t, " busy"},    32'(busy),         32'(e_busy));
        chk({t, " io_en"},   32'(io_en),        32'(e_en));
        chk({t, " done"},    32'(done),         32'(e_done));
        chk({t, " pwm_dis"}, 32'(pwm_dis),      32'(e_dis));
        chk({t, " aborted"}, 32'(aborted),      32'(e_abt));
        chk({t, " cfg_err"}, 32'(cfg_err),      32'(e_err));
        chk({t, " cnt"},     32'(cycle_cnt),    32'(e_cnt));
        chk({t, " die"},     die_period,        e_die);
        chk({t, " pulse"},   pulse_period,      e_pul);
    endtask

    task automatic cfg_write(input int d, input int p, input int b, input int g);
        cfg_wr           = 1'b1;
        cfg_die_period   = 32'(d);
        cfg_pulse_period = 32'(p);
        cfg_burst_count  = 16'(b);
        cfg_gap          = 16'(g);
        start            = 1'b0;
        stop             = 1'b0;
        pulse_valid      = 1'b0;
        tick();
        cfg_wr = 1'b0;
    endtask

    // stop_mode: -1 no stop, -2 stop in a random busy window, k>=0 stop together with k-th completion
    task automatic run_burst(input string ph, input int d, input int p, input int burst,
                             input int gap, input int stop_mode, input bit reconfig);
        int fire[$];
        int pv[$];
        int last, s, fin, cnt;
        bit stp, in_wait, is_fire;
        fire.push_back(2);
        for (int i = 0; i < burst; i++) begin
            pv.push_back(fire[i] + 1 + int'($urandom_range(0, 3)));
            if (i < burst - 1) fire.push_back(pv[i] + 1 + gap);
        end
        last = pv[burst-1];
        stp  = (stop_mode != -1);
        s    = 0;
        if (stop_mode >= 0) s = pv[stop_mode];
        else if (stop_mode == -2) s = int'($urandom_range(2, 32'(last)));
        fin = stp ? s + 4 : last + 2;
        start = 1'b1; stop = 1'b0; pulse_valid = 1'b0; cfg_wr = 1'b0;
        for (int w = 1; w <= fin; w++) begin
            tick();
            cnt = 0;
            foreach (pv[j]) if (pv[j] < w && (!stp || pv[j] < s)) cnt++;
            is_fire = 1'b0;
            foreach (fire[j]) if (fire[j] == w && (!stp || w <= s)) is_fire = 1'b1;
            check_all(ph, w,
                      stp ? (w <= s + 3) : (w <= last + 1),
                      is_fire,
                      !stp && (w == last + 1),
                      stp && (w == s + 1 || w == s + 2),
                      stp && (w == s + 3),
                      1'b0,
                      (w == 1) ? prev_cnt : 16'(cnt),
                      (w == 1) ? sh_die : 32'(d),
                      (w == 1) ? sh_pul : 32'(p));
            start  = 1'b0;
            stop   = stp && (w == s);
            cfg_wr = 1'b0;
            in_wait = 1'b0;
            foreach (fire[j]) if (w > fire[j] && w <= pv[j]) in_wait = 1'b1;
            pulse_valid = 1'b0;
            foreach (pv[j]) if (pv[j] == w) pulse_valid = 1'b1;
            if (!in_wait && $urandom_range(0, 3) == 0) pulse_valid = 1'b1;
            if (reconfig && w == fire[1] + 1) begin
                cfg_wr = 1'b1; cfg_die_period = 32'd9; cfg_pulse_period = 32'd9;
            end
        end
        cnt = 0;
        foreach (pv[j]) if (!stp || pv[j] < s) cnt++;
        prev_cnt = 16'(cnt);
        sh_die = 32'(d);
        sh_pul = 32'(p);
    endtask

    task automatic run_reject(input string ph);
        start = 1'b1; stop = 1'b0; pulse_valid = 1'b0; cfg_wr = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            tick();
            check_all(ph, w, w == 1, 1'b0, 1'b0, 1'b0, 1'b0, w == 1, prev_cnt, sh_die, sh_pul);
            start = 1'b0;
            pulse_valid = 1'($urandom_range(0, 1));
        end
        pulse_valid = 1'b0;
    endtask

    initial begin
        int d, p, b, g, m;
        // reset state while io_rst is held low
        tick();
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
        @(negedge io_clk);
        io_rst = 1'b1;
        tick();

        cfg_write(3, 5, 4, 0);
        run_burst("normal", 3, 5, 4, 0, -1, 1'b0);

        cfg_write(3, 5, 3, 6);
        run_burst("gap", 3, 5, 3, 6, -1, 1'b0);

        cfg_write(3, 0, 2, 0);
        run_reject("reject");

        cfg_write(4, 7, 5, 1);
        run_burst("collide", 4, 7, 5, 1, 1, 1'b0);

        cfg_write(5, 6, 3, 0);
        run_burst("reconf", 5, 6, 3, 0, -1, 1'b1);
        run_burst("reconf2", 9, 9, 3, 0, -1, 1'b0);

        cfg_write(2, 2, 1, 0);
        run_burst("burst1", 2, 2, 1, 0, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            d = int'($urandom_range(1, 255));
            p = int'($urandom_range(1, 255));
            b = int'($urandom_range(1, 5));
            g = int'($urandom_range(0, 3));
            m = ($urandom_range(0, 1) == 1) ? -2 : -1;
            cfg_write(d, p, b, g);
            run_burst($sformatf("rand%0d", r), d, p, b, g, m, 1'b0);
        end

        // asynchronous reset while idling in a gap
        cfg_write(3, 5, 3, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rstgap fire", 32'(io_en), 32'd1);
        tick();
        pulse_valid = 1'b1;
        tick();
        pulse_valid = 1'b0;
        tick();
        tick();
        chk("rstgap busy", 32'(busy), 32'd1);
        #2 io_rst = 1'b0;
        #1;
        check_all("rstgap", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
        @(negedge io_clk);
        io_rst = 1'b1;
        sh_die = '0; sh_pul = '0; prev_cnt = '0;
        tick();
        check_all("rstgap idle", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0, 32'd0);
        run_reject("rstgap rej");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
